// File: rtl/x_micro_scope_pkg.sv
// Shared types and defaults for the micro scope dump path.
// Holds the dump FSM state type and the default frame sync byte.
package x_micro_scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_SYNC,
        ST_READ,
        ST_LATCH,
        ST_SEND
    } state_t;

    localparam int          DEF_ADDR_W     = 11;
    localparam int          DEF_DATA_W     = 32;
    localparam logic [7:0]  DEF_SYNC_BYTE  = 8'h5A;
    localparam int          BYTES_PER_WORD = DEF_DATA_W / 8;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/x_micro_scope_dump_if.sv
// Scope control/read port plus the outgoing valid/ready byte stream.
// master = dump engine, slave = scope RAM and UART TX side.
interface x_micro_scope_dump_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              scope_start;
    logic              scope_busy;
    logic              scope_ren;
    logic [ADDR_W-1:0] scope_raddr;
    logic [DATA_W-1:0] scope_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;

    modport master (
        output scope_start, scope_ren, scope_raddr, tx_valid, tx_data,
        input  scope_busy, scope_data, tx_ready
    );

    modport slave (
        input  scope_start, scope_ren, scope_raddr, tx_valid, tx_data,
        output scope_busy, scope_data, tx_ready
    );
endinterface

// File: rtl/x_micro_scope_ser.sv
// Word-to-byte serializer: loads one DATA_W word, emits it LSB byte first
// on a valid/ready stream and pulses o_done on the handshake of the last byte.
module x_micro_scope_ser #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_valid,
    input  logic              i_ready,
    output logic [7:0]        o_byte,
    output logic              o_done
);
    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

    logic [DATA_W-1:0] shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic              hs;

    assign hs     = i_valid && i_ready;
    assign o_done = hs && (idx_q == IDX_LAST);
    assign o_byte = shift_q[7:0];

    // Shift register empties to zero after the last byte, so o_byte idles at 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (i_load) begin
            shift_q <= i_word;
            idx_q   <= '0;
        end else if (hs) begin
            shift_q <= shift_q >> 8;
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end
endmodule

// File: rtl/x_micro_scope_dump.sv
// Arms one scope capture on i_go, then streams SYNC_BYTE followed by every
// captured word (address 0 first, little-endian bytes) to the UART TX.
module x_micro_scope_dump
    import x_micro_scope_pkg::*;
#(
    parameter int         ADDR_W    = DEF_ADDR_W,
    parameter int         DATA_W    = DEF_DATA_W,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_go,
    output logic o_busy,
    x_micro_scope_dump_if.master bus
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              ser_load;
    logic              ser_valid;
    logic              ser_done;
    logic [7:0]        ser_byte;

    x_micro_scope_ser #(.DATA_W(DATA_W)) u_ser (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (ser_load),
        .i_word  (bus.scope_data),
        .i_valid (ser_valid),
        .i_ready (bus.tx_ready),
        .o_byte  (ser_byte),
        .o_done  (ser_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            // Wraps to 0 after the last word through plain ADDR_W overflow.
            if (state_q == ST_SEND && ser_done) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign o_busy          = (state_q != ST_IDLE);
    assign bus.scope_raddr = addr_q;
    assign ser_load        = (state_q == ST_LATCH);
    assign ser_valid       = (state_q == ST_SEND);

    // tx_valid depends on state only, never on tx_ready.
    always_comb begin
        state_d         = state_q;
        bus.scope_start = 1'b0;
        bus.scope_ren   = 1'b0;
        bus.tx_valid    = 1'b0;
        bus.tx_data     = 8'h00;
        unique case (state_q)
            ST_IDLE: begin
                if (i_go && !bus.scope_busy) state_d = ST_START;
            end
            ST_START: begin
                bus.scope_start = 1'b1;
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.scope_busy) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = SYNC_BYTE;
                if (bus.tx_ready) state_d = ST_READ;
            end
            ST_READ: begin
                bus.scope_ren = 1'b1;
                state_d       = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = ser_byte;
                if (ser_done) state_d = (addr_q == ADDR_MAX) ? ST_IDLE : ST_READ;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_x_micro_scope_dump.sv
// Bench for x_micro_scope_dump: scope model with a free-running sample counter,
// byte collector, and a frame reference built from capture arithmetic.
module tb_x_micro_scope_dump;
    import x_micro_scope_pkg::*;

    localparam int AW          = 11;
    localparam int DW          = 32;
    localparam int NW          = 1 << AW;
    localparam int BPW         = BYTES_PER_WORD;
    localparam int FRAME_BYTES = 1 + NW * BPW;

    logic clk = 1'b0;
    logic rst;
    logic go;
    logic busy;

    x_micro_scope_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    x_micro_scope_dump #(.ADDR_W(AW), .DATA_W(DW), .SYNC_BYTE(8'h5A)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_go   (go),
        .o_busy (busy),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Scope model: after a start pulse, captures the counter on each of the next NW edges.
    logic [31:0]   cnt = '0;
    logic [31:0]   start_cnt = '0;
    logic          mdl_busy = 1'b0;
    logic [AW-1:0] wr = '0;
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] rdata = '0;
    logic          force_busy;

    always @(posedge clk) begin
        cnt <= cnt + 1;
        if (bus.scope_start) begin
            mdl_busy  <= 1'b1;
            wr        <= '0;
            start_cnt <= cnt;
        end else if (mdl_busy) begin
            mem[wr] <= cnt;
            wr      <= wr + 1'b1;
            if (wr == AW'(NW - 1)) mdl_busy <= 1'b0;
        end
        if (bus.scope_ren) rdata <= mem[bus.scope_raddr];
    end

    assign bus.scope_busy = mdl_busy | force_busy;
    assign bus.scope_data = rdata;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         starts = 0;
    int         last_hs_cyc = 0;
    int         last_ren_addr = -1;
    logic [7:0] rx_q [$];
    logic       bp_mode = 1'b0;
    logic       ready_force = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive tx_ready after the edge, observe the bus at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.tx_ready = bp_mode ? ($urandom_range(0, 99) < 30) : ready_force;
        @(negedge clk);
        if (prev_stall) begin
            checks++;
            assert (bus.tx_valid === 1'b1 && bus.tx_data === prev_data) else begin
                failures++;
                $error("FAIL stall_hold valid=%0b data=%02h expected_data=%02h",
                       bus.tx_valid, bus.tx_data, prev_data);
            end
        end
        if (bus.tx_valid && bus.tx_ready) begin
            rx_q.push_back(bus.tx_data);
            last_hs_cyc = cyc;
        end
        if (bus.scope_start) starts++;
        if (bus.scope_ren) last_ren_addr = int'(bus.scope_raddr);
        prev_stall = bus.tx_valid && !bus.tx_ready && !rst;
        prev_data  = bus.tx_data;
    endtask

    // Word n of a frame is the sample taken n+1 edges after the start edge.
    task automatic check_frame(input string tag, input int idx0, input logic [31:0] base);
        int          mism;
        int          first;
        logic [31:0] w;
        logic [7:0]  e;
        logic [7:0]  got_b;
        logic [7:0]  exp_b;
        mism  = 0;
        first = -1;
        got_b = '0;
        exp_b = '0;
        for (int i = 0; i < NW * BPW; i++) begin
            w = base + 32'd1 + 32'(i / BPW);
            e = 8'(w >> (8 * (i % BPW)));
            if (rx_q[idx0 + 1 + i] !== e) begin
                mism++;
                if (first < 0) begin
                    first = i;
                    got_b = rx_q[idx0 + 1 + i];
                    exp_b = e;
                end
            end
        end
        chk({tag, "_data_mismatches"}, mism, 0);
        if (first >= 0) chk({tag, "_first_bad_byte"}, got_b, exp_b);
    endtask

    initial begin
        int          idx;
        int          s0;
        int          len1;
        int          len2;
        int          fall_cyc;
        logic        timeout;
        logic [31:0] w0;

        rst          = 1'b1;
        go           = 1'b0;
        force_busy   = 1'b0;
        bus.tx_ready = 1'b0;

        // Reset held with random inputs.
        bp_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            go         = 1'($urandom_range(0, 1));
            force_busy = 1'($urandom_range(0, 1));
            chk("reset_outputs",
                {busy, bus.scope_start, bus.scope_ren, bus.tx_valid, bus.scope_raddr, bus.tx_data}, 0);
        end
        go          = 1'b0;
        force_busy  = 1'b0;
        bp_mode     = 1'b0;
        ready_force = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        chk("release_busy", busy, 0);
        chk("release_valid", bus.tx_valid, 0);

        // i_go while the scope reports busy in IDLE.
        force_busy = 1'b1;
        s0 = starts;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("go_scope_busy_idle", busy, 0);
        chk("go_scope_busy_starts", starts - s0, 0);
        force_busy = 1'b0;
        step();

        // Frame 1: ready tied high, extra go pulses while sending.
        idx = rx_q.size();
        s0  = starts;
        go  = 1'b1;
        step();
        go = 1'b0;
        chk("f1_busy_after_go", busy, 1);
        timeout = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            step();
            go = ((rx_q.size() - idx) >= 100) && ((rx_q.size() - idx) <= 103);
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
        end
        go       = 1'b0;
        fall_cyc = cyc;
        len1     = rx_q.size() - idx;
        chk("f1_timeout", timeout, 0);
        chk("f1_len", len1, FRAME_BYTES);
        chk("f1_starts", starts - s0, 1);
        if (len1 >= 1) chk("f1_sync", rx_q[idx], 8'h5A);
        if (len1 >= FRAME_BYTES) check_frame("f1", idx, start_cnt);
        chk("f1_idle_after_last_byte", fall_cyc - last_hs_cyc, 1);
        chk("f1_last_raddr", last_ren_addr, NW - 1);
        chk("f1_raddr_wrapped", bus.scope_raddr, 0);
        chk("f1_valid_idle", bus.tx_valid, 0);

        // Frame 2: ~30% ready duty.
        step();
        bp_mode = 1'b1;
        idx     = rx_q.size();
        s0      = starts;
        go      = 1'b1;
        step();
        go = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 45000; i++) begin
            step();
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
        end
        len2 = rx_q.size() - idx;
        chk("f2_timeout", timeout, 0);
        chk("f2_len_vs_f1", len2, len1);
        chk("f2_starts", starts - s0, 1);
        if (len2 >= 1) chk("f2_sync", rx_q[idx], 8'h5A);
        if (len2 >= FRAME_BYTES) check_frame("f2", idx, start_cnt);
        chk("f2_last_raddr", last_ren_addr, NW - 1);
        chk("f2_raddr_wrapped", bus.scope_raddr, 0);

        // Reset in the middle of a frame.
        bp_mode     = 1'b0;
        ready_force = 1'b1;
        step();
        idx = rx_q.size();
        go  = 1'b1;
        step();
        go = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            step();
            if ((rx_q.size() - idx) >= 1000) begin
                timeout = 1'b0;
                break;
            end
        end
        chk("mid_reach_1000_timeout", timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_reset_outputs",
            {busy, bus.scope_start, bus.scope_ren, bus.tx_valid, bus.scope_raddr, bus.tx_data}, 0);
        prev_stall = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("mid_reset_busy_after", busy, 0);

        idx = rx_q.size();
        s0  = starts;
        go  = 1'b1;
        step();
        go = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            step();
            if ((rx_q.size() - idx) >= 5) begin
                timeout = 1'b0;
                break;
            end
        end
        chk("restart_timeout", timeout, 0);
        chk("restart_starts", starts - s0, 1);
        w0 = start_cnt + 32'd1;
        if ((rx_q.size() - idx) >= 5) begin
            chk("restart_sync", rx_q[idx], 8'h5A);
            chk("restart_word0", {rx_q[idx + 4], rx_q[idx + 3], rx_q[idx + 2], rx_q[idx + 1]}, w0);
        end
        chk("restart_first_raddr", last_ren_addr, 0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
